// File: rtl/riscv_dp_storeunit.sv
// riscv_dp_storeunit
// Store-side datapath unit. It accepts a single sb/sh/sw request, rotates the
// store data into byte lanes and generates byte enables. A store that crosses
// a 32-bit word boundary is split into two word-aligned write beats, and each
// beat is held on the memory port until it is acknowledged.
module riscv_dp_storeunit #(
  parameter int MP_DATA_WIDTH = 32,
  parameter int MP_ADDR_WIDTH = 32
) (
  input  logic                     iclk,
  input  logic                     irst_n,
  input  logic                     ivalid,
  output logic                     oready,
  input  logic [MP_ADDR_WIDTH-1:0] iaddr,
  input  logic [2:0]               ifunct3,
  input  logic [MP_DATA_WIDTH-1:0] idata,
  output logic                     omem_req,
  input  logic                     imem_ack,
  output logic [MP_ADDR_WIDTH-1:0] omem_addr,
  output logic [MP_DATA_WIDTH-1:0] omem_wdata,
  output logic [3:0]               omem_be,
  output logic                     odone,
  output logic                     oerr
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BEAT0 = 2'd1,
    S_BEAT1 = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [MP_ADDR_WIDTH-1:0] r_addr;
  logic [MP_DATA_WIDTH-1:0] r_wdata;
  logic [3:0]               r_be;
  logic [3:0]               r_be_hi;
  logic                     r_split;
  logic                     r_done;
  logic                     r_err;

  logic [1:0]               w_off;
  logic                     w_legal;
  logic [3:0]               w_base_mask;
  logic [7:0]               w_mask8;
  logic [MP_DATA_WIDTH-1:0] w_rot;
  logic                     w_accept;

  assign w_off    = iaddr[1:0];
  assign w_accept = ivalid && (r_state == S_IDLE);
  assign w_mask8  = {4'b0000, w_base_mask} << w_off;

  // Decode the store width into a base byte mask; unknown codes are illegal
  always_comb begin
    w_legal     = 1'b1;
    w_base_mask = 4'b0000;
    case (ifunct3)
      3'b000:  w_base_mask = 4'b0001;
      3'b001:  w_base_mask = 4'b0011;
      3'b010:  w_base_mask = 4'b1111;
      default: w_legal     = 1'b0;
    endcase
  end

  // Rotate the store data left by 8*offset so each byte lands in its lane
  always_comb begin
    w_rot = idata;
    case (w_off)
      2'd1:    w_rot = {idata[23:0], idata[31:24]};
      2'd2:    w_rot = {idata[15:0], idata[31:16]};
      2'd3:    w_rot = {idata[7:0],  idata[31:8]};
      default: w_rot = idata;
    endcase
  end

  // State register
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  // Next-state logic; illegal requests never leave IDLE
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && w_legal) w_state_next = S_BEAT0;
      S_BEAT0: if (imem_ack) w_state_next = r_split ? S_BEAT1 : S_IDLE;
      S_BEAT1: if (imem_ack) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    oready   = (r_state == S_IDLE);
    omem_req = (r_state == S_BEAT0) || (r_state == S_BEAT1);
  end

  // Beat payload registers and completion pulses; payload is cleared in IDLE
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= 4'b0000;
      r_be_hi <= 4'b0000;
      r_split <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_legal) begin
              r_addr  <= {iaddr[MP_ADDR_WIDTH-1:2], 2'b00};
              r_wdata <= w_rot;
              r_be    <= w_mask8[3:0];
              r_be_hi <= w_mask8[7:4];
              r_split <= |w_mask8[7:4];
            end else begin
              r_done <= 1'b1;
              r_err  <= 1'b1;
            end
          end
        end
        S_BEAT0: begin
          if (imem_ack) begin
            if (r_split) begin
              // Second beat targets the next word; address wraps naturally
              r_addr <= r_addr + {{(MP_ADDR_WIDTH-3){1'b0}}, 3'b100};
              r_be   <= r_be_hi;
            end else begin
              r_addr  <= '0;
              r_wdata <= '0;
              r_be    <= 4'b0000;
              r_done  <= 1'b1;
            end
          end
        end
        S_BEAT1: begin
          if (imem_ack) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= 4'b0000;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_addr  <= '0;
          r_wdata <= '0;
          r_be    <= 4'b0000;
        end
      endcase
    end
  end

  assign omem_addr  = r_addr;
  assign omem_wdata = r_wdata;
  assign omem_be    = r_be;
  assign odone      = r_done;
  assign oerr       = r_err;

endmodule

// File: tb/tb_riscv_dp_storeunit.sv
// Directed bench for riscv_dp_storeunit: walks through single-beat, split,
// wrapping, illegal-funct3 and reset-abort stores with hand-computed values.
module tb_riscv_dp_storeunit;

  logic        iclk;
  logic        irst_n;
  logic        ivalid;
  logic        oready;
  logic [31:0] iaddr;
  logic [2:0]  ifunct3;
  logic [31:0] idata;
  logic        omem_req;
  logic        imem_ack;
  logic [31:0] omem_addr;
  logic [31:0] omem_wdata;
  logic [3:0]  omem_be;
  logic        odone;
  logic        oerr;

  int errors = 0;
  int checks = 0;

  riscv_dp_storeunit #(
    .MP_DATA_WIDTH(32),
    .MP_ADDR_WIDTH(32)
  ) dut (
    .iclk      (iclk),
    .irst_n    (irst_n),
    .ivalid    (ivalid),
    .oready    (oready),
    .iaddr     (iaddr),
    .ifunct3   (ifunct3),
    .idata     (idata),
    .omem_req  (omem_req),
    .imem_ack  (imem_ack),
    .omem_addr (omem_addr),
    .omem_wdata(omem_wdata),
    .omem_be   (omem_be),
    .odone     (odone),
    .oerr      (oerr)
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and settle 1 time unit past it
  task automatic step();
    @(posedge iclk);
    #1;
  endtask

  task automatic chk_beat(input string tag, input logic [31:0] a, input logic [3:0] be,
                          input logic [31:0] wd);
    chk({tag, ".req"},   {31'd0, omem_req}, 32'd1);
    chk({tag, ".addr"},  omem_addr, a);
    chk({tag, ".be"},    {28'd0, omem_be}, {28'd0, be});
    chk({tag, ".wdata"}, omem_wdata, wd);
    chk({tag, ".done"},  {31'd0, odone}, 32'd0);
    chk({tag, ".ready"}, {31'd0, oready}, 32'd0);
  endtask

  task automatic chk_done(input string tag);
    chk({tag, ".done"},  {31'd0, odone}, 32'd1);
    chk({tag, ".err"},   {31'd0, oerr}, 32'd0);
    chk({tag, ".ready"}, {31'd0, oready}, 32'd1);
    chk({tag, ".req"},   {31'd0, omem_req}, 32'd0);
    chk({tag, ".be"},    {28'd0, omem_be}, 32'd0);
    chk({tag, ".addr"},  omem_addr, 32'd0);
  endtask

  task automatic issue(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] d);
    ivalid  = 1'b1;
    iaddr   = a;
    ifunct3 = f3;
    idata   = d;
    step();
    ivalid  = 1'b0;
    iaddr   = 32'h0;
    idata   = 32'h0;
  endtask

  initial begin
    irst_n   = 1'b0;
    ivalid   = 1'b0;
    iaddr    = 32'h0;
    ifunct3  = 3'b000;
    idata    = 32'h0;
    imem_ack = 1'b0;

    // Reset state
    #12;
    chk("rst.ready", {31'd0, oready}, 32'd1);
    chk("rst.req",   {31'd0, omem_req}, 32'd0);
    chk("rst.addr",  omem_addr, 32'd0);
    chk("rst.wdata", omem_wdata, 32'd0);
    chk("rst.be",    {28'd0, omem_be}, 32'd0);
    chk("rst.done",  {31'd0, odone}, 32'd0);
    chk("rst.err",   {31'd0, oerr}, 32'd0);
    @(negedge iclk);
    irst_n = 1'b1;
    step();

    // sb to 0x1003, ack held high
    imem_ack = 1'b1;
    issue(32'h0000_1003, 3'b000, 32'hAABB_CCDD);
    chk_beat("sb.b0", 32'h0000_1000, 4'b1000, 32'hDDAA_BBCC);
    step();
    chk_done("sb.end");
    step();
    chk("sb.pulse", {31'd0, odone}, 32'd0);

    // sh to 0x2003: split across words
    issue(32'h0000_2003, 3'b001, 32'h0000_1234);
    chk_beat("sh.b0", 32'h0000_2000, 4'b1000, 32'h3400_0012);
    step();
    chk_beat("sh.b1", 32'h0000_2004, 4'b0001, 32'h3400_0012);
    step();
    chk_done("sh.end");
    step();
    chk("sh.pulse", {31'd0, odone}, 32'd0);

    // sw to 0x3002 with ack delayed 3 cycles per beat
    imem_ack = 1'b0;
    issue(32'h0000_3002, 3'b010, 32'h1122_3344);
    chk_beat("swd.b0", 32'h0000_3000, 4'b1100, 32'h3344_1122);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_beat("swd.b0wait", 32'h0000_3000, 4'b1100, 32'h3344_1122);
    end
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    chk_beat("swd.b1", 32'h0000_3004, 4'b0011, 32'h3344_1122);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_beat("swd.b1wait", 32'h0000_3004, 4'b0011, 32'h3344_1122);
    end
    imem_ack = 1'b1;
    step();
    chk_done("swd.end");

    // sw to 0xFFFFFFFE: second beat wraps to address 0
    issue(32'hFFFF_FFFE, 3'b010, 32'hCAFE_F00D);
    chk_beat("wrap.b0", 32'hFFFF_FFFC, 4'b1100, 32'hF00D_CAFE);
    step();
    chk_beat("wrap.b1", 32'h0000_0000, 4'b0011, 32'hF00D_CAFE);
    step();
    chk_done("wrap.end");

    // Illegal funct3 011
    issue(32'h0000_1000, 3'b011, 32'h1234_5678);
    chk("ill.req",   {31'd0, omem_req}, 32'd0);
    chk("ill.done",  {31'd0, odone}, 32'd1);
    chk("ill.err",   {31'd0, oerr}, 32'd1);
    chk("ill.ready", {31'd0, oready}, 32'd1);
    step();
    chk("ill.done2", {31'd0, odone}, 32'd0);
    chk("ill.err2",  {31'd0, oerr}, 32'd0);
    chk("ill.req2",  {31'd0, omem_req}, 32'd0);

    // Reset while in BEAT1
    issue(32'h0000_5001, 3'b010, 32'hA1B2_C3D4);
    chk_beat("ab.b0", 32'h0000_5000, 4'b1110, 32'hB2C3_D4A1);
    step();
    chk_beat("ab.b1", 32'h0000_5004, 4'b0001, 32'hB2C3_D4A1);
    #2;
    irst_n = 1'b0;
    #1;
    chk("ab.req",   {31'd0, omem_req}, 32'd0);
    chk("ab.be",    {28'd0, omem_be}, 32'd0);
    chk("ab.done",  {31'd0, odone}, 32'd0);
    chk("ab.ready", {31'd0, oready}, 32'd1);
    @(negedge iclk);
    irst_n = 1'b1;
    step();
    chk("ab.nodone", {31'd0, odone}, 32'd0);

    // sw to 0x4000 after reset completes normally
    issue(32'h0000_4000, 3'b010, 32'h1234_5678);
    chk_beat("aw.b0", 32'h0000_4000, 4'b1111, 32'h1234_5678);
    step();
    chk_done("aw.end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
